// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/write-back sequencer for the RV32I subset core.
// State-only strobes are registered from the next state; handshake, branch and ALU-field terms are combined live.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_LIVE   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_ALUWB,
    S_MEMADDR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_BRANCH,
    S_JAL,
    S_JALWB,
    S_TRAP
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] aluOp_q;
  logic [1:0] srcA_q;
  logic [1:0] srcB_q;
  logic [1:0] resSrc_q;
  logic       adrSrc_q;
  logic       memRead_q;
  logic       memWrite_q;
  logic       pcWrite_q;
  logic       regWrite_q;
  logic       done_q;
  logic       illegal_q;

  logic       isRtype;
  logic [2:0] aluDecOp;
  logic       aluDecBad;
  logic       branchBad;
  logic       branchTaken;

  // ALU operation and legality for R/I arithmetic instructions.
  always_comb begin
    isRtype   = (opcode == OP_R);
    aluDecOp  = ALU_ADD;
    aluDecBad = 1'b0;
    case (funct3)
      3'b000:  aluDecOp = (isRtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  aluDecOp = ALU_SLL;
      3'b010:  aluDecOp = ALU_SLT;
      3'b100:  aluDecOp = ALU_XOR;
      3'b101: begin
        aluDecOp  = ALU_SRL;
        aluDecBad = funct7b5;
      end
      3'b110:  aluDecOp = ALU_OR;
      3'b111:  aluDecOp = ALU_AND;
      default: aluDecBad = 1'b1;
    endcase
    branchBad   = (funct3[2:1] != 2'b00);
    branchTaken = funct3[0] ? !zero : zero;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R, OP_I:        state_d = aluDecBad ? S_TRAP : S_EXECUTE;
          OP_LOAD, OP_STORE: state_d = S_MEMADDR;
          OP_BRANCH:         state_d = branchBad ? S_TRAP : S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_EXECUTE:  state_d = S_ALUWB;
      S_MEMADDR:  state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_ALUWB, S_MEMWB, S_JALWB, S_BRANCH: state_d = S_FETCH;
      S_JAL:      state_d = S_JALWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
  end

  // State register plus the purely state-decoded strobes, loaded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      aluOp_q    <= ALU_ADD;
      srcA_q     <= SRCA_PC;
      srcB_q     <= SRCB_RS2;
      resSrc_q   <= RES_ALUOUT;
      adrSrc_q   <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      pcWrite_q  <= 1'b0;
      regWrite_q <= 1'b0;
      done_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      aluOp_q    <= ALU_ADD;
      srcA_q     <= SRCA_PC;
      srcB_q     <= SRCB_RS2;
      resSrc_q   <= RES_ALUOUT;
      adrSrc_q   <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      pcWrite_q  <= 1'b0;
      regWrite_q <= 1'b0;
      done_q     <= 1'b0;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
      case (state_d)
        S_FETCH: begin
          memRead_q <= 1'b1;
          srcB_q    <= SRCB_FOUR;
        end
        S_DECODE: begin
          srcA_q <= SRCA_OLDPC;
          srcB_q <= SRCB_IMM;
        end
        S_EXECUTE: begin
          srcA_q <= SRCA_RS1;
          srcB_q <= (opcode == OP_R) ? SRCB_RS2 : SRCB_IMM;
        end
        S_ALUWB: begin
          regWrite_q <= 1'b1;
          done_q     <= 1'b1;
        end
        S_MEMADDR: begin
          srcA_q <= SRCA_RS1;
          srcB_q <= SRCB_IMM;
        end
        S_MEMREAD: begin
          memRead_q <= 1'b1;
          adrSrc_q  <= 1'b1;
        end
        S_MEMWB: begin
          regWrite_q <= 1'b1;
          resSrc_q   <= RES_MEM;
          done_q     <= 1'b1;
        end
        S_MEMWRITE: begin
          memWrite_q <= 1'b1;
          adrSrc_q   <= 1'b1;
        end
        S_BRANCH: begin
          srcA_q  <= SRCA_RS1;
          aluOp_q <= ALU_SUB;
          done_q  <= 1'b1;
        end
        S_JAL: begin
          srcA_q    <= SRCA_OLDPC;
          srcB_q    <= SRCB_FOUR;
          pcWrite_q <= 1'b1;
        end
        S_JALWB: begin
          regWrite_q <= 1'b1;
          resSrc_q   <= RES_LIVE;
          done_q     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Terms that must follow mem_ready, zero or the instruction fields within the current cycle.
  always_comb begin
    alu_op     = (state_q == S_EXECUTE) ? aluDecOp : aluOp_q;
    alu_src_a  = srcA_q;
    alu_src_b  = srcB_q;
    adr_src    = adrSrc_q;
    mem_read   = memRead_q;
    mem_write  = memWrite_q;
    reg_write  = regWrite_q;
    illegal    = illegal_q;
    ir_write   = (state_q == S_FETCH) && mem_ready;
    result_src = ir_write ? RES_LIVE : resSrc_q;
    pc_write   = pcWrite_q || ir_write || ((state_q == S_BRANCH) && branchTaken);
    instr_done = done_q || ((state_q == S_MEMWRITE) && mem_ready);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: table-driven check of instruction sequencing plus hand-written
// wait-state, trap and asynchronous-reset sequences for multicycle_ctrl.
module tb_multicycle_ctrl;

  localparam int MAXC = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] alu_op;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic       adr_src, mem_read, mem_write, ir_write, pc_write, reg_write;
  logic       instr_done, illegal;
  logic [16:0] allOut;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .adr_src(adr_src),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .instr_done(instr_done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign allOut = {alu_op, alu_src_a, alu_src_b, result_src, adr_src, mem_read,
                   mem_write, ir_write, pc_write, reg_write, instr_done, illegal};

  typedef struct {
    string      name;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         expCycles;
    logic [2:0] expAlu3;
    logic       expPc3;
    logic       expRegLast;
    logic [1:0] expResLast;
    logic       expIllegal;
  } vec_t;

  vec_t vecs[$];

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Hold reset across a clock edge, release it at a falling edge, and step into FETCH.
  task automatic resetDut();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from FETCH; readyMask bit c-1 is mem_ready in cycle c.
  task automatic applyStimulus(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                               input logic z, input logic [15:0] readyMask,
                               output int cycles, output logic [2:0] alu3, output logic pc3,
                               output logic regLast, output logic [1:0] resLast,
                               output int irCount, output int pcCount, output int memRdCount);
    opcode = opc; funct3 = f3; funct7b5 = f7; zero = z;
    cycles = 0; alu3 = '0; pc3 = 1'b0; regLast = 1'b0; resLast = '0;
    irCount = 0; pcCount = 0; memRdCount = 0;
    for (int c = 1; c <= MAXC; c++) begin
      mem_ready = readyMask[c-1];
      @(negedge clk);
      if (ir_write) irCount++;
      if (pc_write) pcCount++;
      if (mem_read) memRdCount++;
      if (c == 3) begin
        alu3 = alu_op;
        pc3  = pc_write;
      end
      if (instr_done) begin
        cycles  = c;
        regLast = reg_write;
        resLast = result_src;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cyc, irc, pcc, mrc;
    logic [2:0] a3;
    logic p3, rl;
    logic [1:0] rs;
    int bad;

    vecs.push_back('{"R_SUB",   7'b0110011, 3'b000, 1'b1, 1'b0, 4, 3'b001, 1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{"R_ADD",   7'b0110011, 3'b000, 1'b0, 1'b1, 4, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{"R_SLT",   7'b0110011, 3'b010, 1'b0, 1'b0, 4, 3'b111, 1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{"R_XOR",   7'b0110011, 3'b100, 1'b0, 1'b0, 4, 3'b100, 1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{"R_SLL",   7'b0110011, 3'b001, 1'b0, 1'b0, 4, 3'b101, 1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{"I_ADDI",  7'b0010011, 3'b000, 1'b1, 1'b0, 4, 3'b000, 1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{"I_ORI",   7'b0010011, 3'b110, 1'b0, 1'b0, 4, 3'b011, 1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{"I_ANDI",  7'b0010011, 3'b111, 1'b0, 1'b0, 4, 3'b010, 1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{"I_SRLI",  7'b0010011, 3'b101, 1'b0, 1'b0, 4, 3'b110, 1'b0, 1'b1, 2'b00, 1'b0});
    vecs.push_back('{"LW",      7'b0000011, 3'b010, 1'b0, 1'b0, 5, 3'b000, 1'b0, 1'b1, 2'b01, 1'b0});
    vecs.push_back('{"SW",      7'b0100011, 3'b010, 1'b0, 1'b1, 4, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0});
    vecs.push_back('{"BEQ_T",   7'b1100011, 3'b000, 1'b0, 1'b1, 3, 3'b001, 1'b1, 1'b0, 2'b00, 1'b0});
    vecs.push_back('{"BEQ_NT",  7'b1100011, 3'b000, 1'b0, 1'b0, 3, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0});
    vecs.push_back('{"BNE_NT",  7'b1100011, 3'b001, 1'b0, 1'b1, 3, 3'b001, 1'b0, 1'b0, 2'b00, 1'b0});
    vecs.push_back('{"BNE_T",   7'b1100011, 3'b001, 1'b0, 1'b0, 3, 3'b001, 1'b1, 1'b0, 2'b00, 1'b0});
    vecs.push_back('{"JAL",     7'b1101111, 3'b000, 1'b0, 1'b0, 4, 3'b000, 1'b1, 1'b1, 2'b10, 1'b0});
    vecs.push_back('{"BAD_SLTU",7'b0110011, 3'b011, 1'b0, 1'b0, 0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1});
    vecs.push_back('{"BAD_SRA", 7'b0110011, 3'b101, 1'b1, 1'b0, 0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1});
    vecs.push_back('{"BAD_ISLT",7'b0010011, 3'b011, 1'b0, 1'b0, 0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1});
    vecs.push_back('{"BAD_BR",  7'b1100011, 3'b100, 1'b0, 1'b1, 0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1});
    vecs.push_back('{"BAD_OPC", 7'b0000000, 3'b000, 1'b0, 1'b0, 0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b1});

    // Reset state, then the idle cycle and the first fetch.
    #7;
    checkOutput("resetOutputs", 32'(allOut), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    checkOutput("idleAfterReset", 32'(allOut), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("firstFetchMemRead", 32'(mem_read), 32'h1);
    checkOutput("firstFetchSrcB", 32'(alu_src_b), 32'h2);
    checkOutput("fetchWaitIrWrite", 32'(ir_write), 32'h0);

    foreach (vecs[i]) begin
      resetDut();
      applyStimulus(vecs[i].opc, vecs[i].f3, vecs[i].f7, vecs[i].z, 16'hFFFF,
                    cyc, a3, p3, rl, rs, irc, pcc, mrc);
      checkOutput({vecs[i].name, ".cycles"}, 32'(cyc), 32'(vecs[i].expCycles));
      checkOutput({vecs[i].name, ".aluOp3"}, 32'(a3), 32'(vecs[i].expAlu3));
      checkOutput({vecs[i].name, ".pcWrite3"}, 32'(p3), 32'(vecs[i].expPc3));
      checkOutput({vecs[i].name, ".regWriteLast"}, 32'(rl), 32'(vecs[i].expRegLast));
      checkOutput({vecs[i].name, ".resultSrcLast"}, 32'(rs), 32'(vecs[i].expResLast));
      checkOutput({vecs[i].name, ".illegal"}, 32'(illegal), 32'(vecs[i].expIllegal));
      checkOutput({vecs[i].name, ".irWrites"}, 32'(irc), 32'h1);
      checkOutput({vecs[i].name, ".pcWrites"}, 32'(pcc), 32'(1 + int'(vecs[i].expPc3)));
    end

    // Load with two fetch waits and three read waits.
    resetDut();
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 16'hFF1C, cyc, a3, p3, rl, rs, irc, pcc, mrc);
    checkOutput("loadWait.cycles", 32'(cyc), 32'd10);
    checkOutput("loadWait.irWrites", 32'(irc), 32'h1);
    checkOutput("loadWait.pcWrites", 32'(pcc), 32'h1);
    checkOutput("loadWait.memReadCycles", 32'(mrc), 32'd7);
    checkOutput("loadWait.regWriteLast", 32'(rl), 32'h1);
    checkOutput("loadWait.resultSrcLast", 32'(rs), 32'h1);

    // Store with one write wait completes one cycle later.
    resetDut();
    applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 16'hFFF7, cyc, a3, p3, rl, rs, irc, pcc, mrc);
    checkOutput("storeWait.cycles", 32'(cyc), 32'd5);

    // Illegal instruction: trap holds with strobes low until a reset pulse.
    resetDut();
    applyStimulus(7'b0110011, 3'b011, 1'b0, 1'b0, 16'hFFFF, cyc, a3, p3, rl, rs, irc, pcc, mrc);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      mem_ready = k[0];
      zero = k[1];
      @(negedge clk);
      if (allOut !== 17'h1) bad++;
    end
    checkOutput("trapHoldBadCycles", 32'(bad), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("trapResetClears", 32'(allOut), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    #1;
    checkOutput("trapResetIdle", 32'(allOut), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("fetchAfterTrapReset", 32'(mem_read), 32'h1);

    // Asynchronous reset while a store is waiting in MEMWRITE.
    resetDut();
    opcode = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("memWriteBeforeReset", 32'(mem_write), 32'h1);
    checkOutput("noDoneWhileWaiting", 32'(instr_done), 32'h0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midResetOutputs", 32'(allOut), 32'h0);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midResetHeld", 32'(allOut), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("fetchAfterMidReset", 32'(mem_read), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
